mult_sequencer: RTL and testbench

//   Control FSM for the shift-add multiplier. Drives the ADD/SHIFT/LOAD inputs of the
//   {carry, sum, multiplier} product register. Steers on the register LSB (q0).

---
 rtl/mult_pkg.sv | 49 ++++
 rtl/mult_iter_counter.sv | 27 ++
 rtl/mult_sequencer.sv | 65 ++++++
 tb/tb_mult_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier control path.
package mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        EXAMINE = 3'd2,
        SHIFT   = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic load;
        logic shift;
        logic busy;
        logic ready;
        logic done;
    } seq_outs_t;

    // Next-state rule; unreachable encodings fall back to IDLE.
    function automatic seq_state_t seq_next(seq_state_t s, logic start, logic last);
        seq_state_t n;
        n = IDLE;
        case (s)
            IDLE:    n = start ? LOAD : IDLE;
            LOAD:    n = EXAMINE;
            EXAMINE: n = SHIFT;
            SHIFT:   n = last ? DONE : EXAMINE;
            DONE:    n = start ? LOAD : DONE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    // Moore output decode for a given state.
    function automatic seq_outs_t seq_outs(seq_state_t s);
        seq_outs_t o;
        o = '0;
        o.load  = (s == LOAD);
        o.shift = (s == SHIFT);
        o.busy  = (s == LOAD) || (s == EXAMINE) || (s == SHIFT);
        o.ready = (s == IDLE) || (s == DONE);
        o.done  = (s == DONE);
        return o;
    endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier sequencer; flags the final iteration.
module mult_iter_counter #(
    parameter int unsigned WIDTH = mult_pkg::DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] count;

    // Saturates at WIDTH-1 so the count never wraps.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !last) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for the shift-add multiplier: sequences LOAD, ADD and SHIFT
// on the {carry, sum, multiplier} register and offers a start/ready/done handshake.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    output logic LOAD,
    output logic ADD,
    output logic SHIFT,
    output logic busy,
    output logic ready,
    output logic done
);

    seq_state_t state;
    seq_state_t state_nxt;
    seq_outs_t  outs_nxt;
    logic       last;
    logic       cnt_clr;
    logic       cnt_inc;

    assign cnt_clr = (state == mult_pkg::LOAD);
    assign cnt_inc = (state == mult_pkg::SHIFT);

    mult_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .last  (last)
    );

    assign state_nxt = seq_next(state, start, last);
    assign outs_nxt  = seq_outs(state_nxt);

    // State and registered Moore outputs move together so outputs track state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= mult_pkg::IDLE;
            LOAD  <= 1'b0;
            SHIFT <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            LOAD  <= outs_nxt.load;
            SHIFT <= outs_nxt.shift;
            busy  <= outs_nxt.busy;
            ready <= outs_nxt.ready;
            done  <= outs_nxt.done;
        end
    end

    // Only Mealy output: add the multiplicand when the current multiplier LSB is set.
    assign ADD = (state == mult_pkg::EXAMINE) & q0;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer with a behavioural product-register model.
module tb_mult_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned NCYC  = 2 * WIDTH + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b1;
    logic q0;
    logic LOAD, ADD, SHIFT, busy, ready, done;

    logic [2*WIDTH:0] prod_reg = '0;
    logic [WIDTH-1:0] mplier = '0;
    logic [WIDTH-1:0] mcand = '0;

    int  checks = 0;
    int  errors = 0;
    bit  armed = 1'b0;
    bit  exp_done = 1'b0;

    mult_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .q0    (q0),
        .LOAD  (LOAD),
        .ADD   (ADD),
        .SHIFT (SHIFT),
        .busy  (busy),
        .ready (ready),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Product register datapath beside the sequencer: load, add upper half, shift right.
    assign q0 = prod_reg[0];
    always @(posedge clk) begin
        if (LOAD)
            prod_reg <= {{(WIDTH+1){1'b0}}, mplier};
        else if (ADD)
            prod_reg[2*WIDTH:WIDTH] <= {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        else if (SHIFT)
            prod_reg <= prod_reg >> 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("add_shift_excl", 32'(ADD & SHIFT), 32'd0);
            check("load_excl", 32'(LOAD & (ADD | SHIFT)), 32'd0);
            check("busy_xor_ready", 32'(busy ^ ready), 32'd1);
        end
    end

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("gap_ready", 32'(ready), 32'd1);
            check("gap_load", 32'(LOAD), 32'd0);
            check("gap_done", 32'(done), 32'(exp_done));
        end
    endtask

    // Issue one multiply from a ready state; expected trace follows from the operand bits.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hammer);
        int adds;
        int shifts;
        adds   = 0;
        shifts = 0;
        mplier = a;
        mcand  = b;
        start  = 1'b1;
        @(negedge clk);
        check("load_pulse", 32'(LOAD), 32'd1);
        check("load_done_low", 32'(done), 32'd0);
        check("load_busy", 32'(busy), 32'd1);
        start = hammer;
        for (int k = 1; k <= int'(NCYC); k++) begin
            @(negedge clk);
            adds   += int'(ADD);
            shifts += int'(SHIFT);
            if (k < int'(NCYC)) begin
                check("iter_load", 32'(LOAD), 32'd0);
                check("iter_busy", 32'(busy), 32'd1);
                check("iter_done", 32'(done), 32'd0);
                if (k % 2 == 1) begin
                    check("exam_add", 32'(ADD), 32'(a[(k-1)/2]));
                    check("exam_shift", 32'(SHIFT), 32'd0);
                end else begin
                    check("shift_pulse", 32'(SHIFT), 32'd1);
                    check("shift_add", 32'(ADD), 32'd0);
                end
                start = hammer;
            end else begin
                check("done_rise", 32'(done), 32'd1);
                check("done_ready", 32'(ready), 32'd1);
                check("done_shift", 32'(SHIFT), 32'd0);
                check("product", 32'(prod_reg), 32'(a) * 32'(b));
                start = 1'b0;
            end
        end
        check("add_count", 32'(adds), 32'($countones(a)));
        check("shift_count", 32'(shifts), 32'(WIDTH));
        exp_done = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            armed = 1'b1;
            check("rst_ready", 32'(ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_load", 32'(LOAD), 32'd0);
            check("rst_add", 32'(ADD), 32'd0);
            check("rst_shift", 32'(SHIFT), 32'd0);
        end
        reset = 1'b0;
        start = 1'b0;
        idle_gap(2);

        run_op(4'd9, 4'd8, 1'b0);
        idle_gap(1);
        run_op(4'd0, 4'd7, 1'b0);
        run_op(4'd15, 4'd15, 1'b1);
        idle_gap(2);

        // Abort: reset during the EXAMINE cycle following the second SHIFT.
        mplier = 4'b1111;
        mcand  = 4'd3;
        start  = 1'b1;
        @(negedge clk);
        check("abort_load", 32'(LOAD), 32'd1);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_done = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("abort_add", 32'(ADD), 32'd0);
            check("abort_shift", 32'(SHIFT), 32'd0);
            idle_gap(1);
        end

        for (int n = 0; n < 24; n++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            idle_gap(int'($urandom_range(0, 2)));
            run_op(a, b, bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
